// File: rtl/mcp3208_responder.sv
//------------------------------------------------------------------------------
// Module      : mcp3208_responder
// Description : MCP3208-style SPI ADC responder. Decodes the start/SGL/D2..D0
//               command and returns a 12-bit single-ended or clamped
//               differential result from the ch_data bus.
//               Optional build macro MCP_LSB_TAIL_EN: LSB-first tail after B0.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mcp3208_responder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        sclk,
    input  logic        ncs,
    input  logic        mosi,
    output logic        miso,
    output logic        miso_oe,
    input  logic [95:0] ch_data,
    output logic        sample_strobe,
    output logic        frame_done,
    output logic        frame_error,
    output logic [3:0]  last_cmd
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_START = 3'd1,
        CMD        = 3'd2,
        SAMPLE     = 3'd3,
        DATA       = 3'd4,
        TAIL       = 3'd5
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [SYNC_STAGES-1:0]  r_sclk_sync;
    logic [SYNC_STAGES-1:0]  r_ncs_sync;
    logic [SYNC_STAGES-1:0]  r_mosi_sync;
    logic                    r_sclk_prev;
    logic [3:0]              r_bit_cnt;
    logic [3:0]              w_bit_cnt_nxt;
    logic [2:0]              r_cmd;
    logic [2:0]              w_cmd_nxt;
    logic [3:0]              r_last_cmd;
    logic [3:0]              w_last_cmd_nxt;
    logic [11:0]             r_shift;
    logic [11:0]             w_shift_nxt;
    logic                    r_miso;
    logic                    w_miso_nxt;
    logic                    r_miso_oe;
    logic                    w_miso_oe_nxt;
    logic                    r_sample_strobe;
    logic                    w_sample_strobe_nxt;
    logic                    r_frame_done;
    logic                    w_frame_done_nxt;
    logic                    r_frame_error;
    logic                    w_frame_error_nxt;

    logic                    w_sclk_s;
    logic                    w_ncs_s;
    logic                    w_mosi_s;
    logic                    w_sclk_rise;
    logic                    w_sclk_fall;
    logic [2:0]              w_d;
    logic [6:0]              w_base_a;
    logic [6:0]              w_base_b;
    logic [11:0]             w_ch_a;
    logic [11:0]             w_ch_b;
    logic [12:0]             w_diff;
    logic [11:0]             w_result;
`ifdef MCP_LSB_TAIL_EN
    logic [3:0]              w_tail_idx;
`endif

    assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
    assign w_ncs_s     = r_ncs_sync[SYNC_STAGES-1];
    assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk_s & ~r_sclk_prev;
    assign w_sclk_fall = ~w_sclk_s & r_sclk_prev;

    // Result selection; the 13-bit difference sign bit drives the clamp to 0.
    assign w_d      = r_last_cmd[2:0];
    assign w_base_a = {4'b0000, w_d} * 7'd12;
    assign w_base_b = {4'b0000, w_d ^ 3'b001} * 7'd12;
    assign w_ch_a   = ch_data[w_base_a +: 12];
    assign w_ch_b   = ch_data[w_base_b +: 12];
    assign w_diff   = {1'b0, w_ch_a} - {1'b0, w_ch_b};
    assign w_result = r_last_cmd[3] ? w_ch_a : (w_diff[12] ? 12'h000 : w_diff[11:0]);
`ifdef MCP_LSB_TAIL_EN
    assign w_tail_idx = r_bit_cnt + 4'd1;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= IDLE;
            r_sclk_sync     <= '0;
            r_ncs_sync      <= '1;
            r_mosi_sync     <= '0;
            r_sclk_prev     <= 1'b0;
            r_bit_cnt       <= 4'd0;
            r_cmd           <= 3'd0;
            r_last_cmd      <= 4'h0;
            r_shift         <= 12'h000;
            r_miso          <= 1'b0;
            r_miso_oe       <= 1'b0;
            r_sample_strobe <= 1'b0;
            r_frame_done    <= 1'b0;
            r_frame_error   <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_sclk_sync     <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_ncs_sync      <= {r_ncs_sync[SYNC_STAGES-2:0], ncs};
            r_mosi_sync     <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_sclk_prev     <= w_sclk_s;
            r_bit_cnt       <= w_bit_cnt_nxt;
            r_cmd           <= w_cmd_nxt;
            r_last_cmd      <= w_last_cmd_nxt;
            r_shift         <= w_shift_nxt;
            r_miso          <= w_miso_nxt;
            r_miso_oe       <= w_miso_oe_nxt;
            r_sample_strobe <= w_sample_strobe_nxt;
            r_frame_done    <= w_frame_done_nxt;
            r_frame_error   <= w_frame_error_nxt;
        end
    end

    always_comb begin
        w_state_nxt         = r_state;
        w_bit_cnt_nxt       = r_bit_cnt;
        w_cmd_nxt           = r_cmd;
        w_last_cmd_nxt      = r_last_cmd;
        w_shift_nxt         = r_shift;
        w_miso_nxt          = r_miso;
        w_miso_oe_nxt       = r_miso_oe;
        w_sample_strobe_nxt = 1'b0;
        w_frame_done_nxt    = 1'b0;
        w_frame_error_nxt   = 1'b0;

        if (w_ncs_s) begin
            w_state_nxt       = IDLE;
            w_miso_nxt        = 1'b0;
            w_miso_oe_nxt     = 1'b0;
            w_frame_error_nxt = (r_state == CMD) || (r_state == SAMPLE) || (r_state == DATA);
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt   = WAIT_START;
                    w_bit_cnt_nxt = 4'd0;
                end
                WAIT_START: begin
                    if (w_sclk_rise && w_mosi_s) begin
                        w_state_nxt   = CMD;
                        w_bit_cnt_nxt = 4'd0;
                    end
                end
                CMD: begin
                    if (w_sclk_rise) begin
                        w_cmd_nxt     = {r_cmd[1:0], w_mosi_s};
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                        if (r_bit_cnt == 4'd3) begin
                            w_last_cmd_nxt = {r_cmd, w_mosi_s};
                            w_state_nxt    = SAMPLE;
                        end
                    end
                end
                SAMPLE: begin
                    if (w_sclk_rise) begin
                        w_shift_nxt         = w_result;
                        w_sample_strobe_nxt = 1'b1;
                        w_bit_cnt_nxt       = 4'd0;
                        w_state_nxt         = DATA;
                    end
                end
                DATA: begin
                    // Count 0 is the null bit; the rotate leaves r_shift intact after B0.
                    if (w_sclk_fall) begin
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                        if (r_bit_cnt == 4'd0) begin
                            w_miso_nxt    = 1'b0;
                            w_miso_oe_nxt = 1'b1;
                        end else begin
                            w_miso_nxt  = r_shift[11];
                            w_shift_nxt = {r_shift[10:0], r_shift[11]};
                            if (r_bit_cnt == 4'd12) begin
                                w_frame_done_nxt = 1'b1;
                                w_bit_cnt_nxt    = 4'd0;
                                w_state_nxt      = TAIL;
                            end
                        end
                    end
                end
                TAIL: begin
                    if (w_sclk_fall) begin
`ifdef MCP_LSB_TAIL_EN
                        if (r_bit_cnt < 4'd11) begin
                            w_miso_nxt    = r_shift[w_tail_idx];
                            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                        end else begin
                            w_miso_nxt = 1'b0;
                        end
`else
                        w_miso_nxt = 1'b0;
`endif
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    assign miso          = r_miso & r_miso_oe;
    assign miso_oe       = r_miso_oe;
    assign sample_strobe = r_sample_strobe;
    assign frame_done    = r_frame_done;
    assign frame_error   = r_frame_error;
    assign last_cmd      = r_last_cmd;

endmodule

`default_nettype wire

// File: tb/tb_mcp3208_responder.sv
//------------------------------------------------------------------------------
// Module      : tb_mcp3208_responder
// Description : Directed self-checking bench; acts as the SPI master.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mcp3208_responder;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        sclk;
    logic        ncs;
    logic        mosi;
    logic        miso;
    logic        miso_oe;
    logic [95:0] ch_fixed;
    logic [95:0] ch_rand;
    logic        scramble;
    logic [95:0] ch_data;
    logic        sample_strobe;
    logic        frame_done;
    logic        frame_error;
    logic [3:0]  last_cmd;

    int          n_checks = 0;
    int          n_fails  = 0;
    int          n_strobe = 0;
    int          n_done   = 0;
    int          n_err    = 0;
    logic [11:0] iso_captured = 12'h000;

    always #5 clock = ~clock;

    assign ch_data = scramble ? ch_rand : ch_fixed;

    mcp3208_responder #(.SYNC_STAGES(2)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .sclk          (sclk),
        .ncs           (ncs),
        .mosi          (mosi),
        .miso          (miso),
        .miso_oe       (miso_oe),
        .ch_data       (ch_data),
        .sample_strobe (sample_strobe),
        .frame_done    (frame_done),
        .frame_error   (frame_error),
        .last_cmd      (last_cmd)
    );

    always @(negedge clock) begin
        if (sample_strobe) n_strobe++;
        if (frame_done)    n_done++;
        if (frame_error)   n_err++;
    end

    // The strobe is registered on the edge that sampled ch_data, so the value
    // seen at this negedge is the one the responder latched.
    always @(negedge clock) begin
        if (scramble) begin
            if (sample_strobe) iso_captured = ch_rand[35:24];
            ch_rand = {$urandom(), $urandom(), $urandom()};
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_ch(input int n, input logic [11:0] v);
        ch_fixed[n*12 +: 12] = v;
    endtask

    task automatic half_sclk();
        repeat (8) @(posedge clock);
        #1;
    endtask

    // Master frame: 5 zeros, start, SGL, D2..D0, then idle mosi. Rise 12 is the
    // null bit, rises 13..24 carry B11..B0, rises 25..35 the tail.
    task automatic run_frame(input logic sgl, input logic [2:0] d, input int n_rises,
                             input bit leave_cs, output logic [11:0] rx,
                             output logic [10:0] tail, output logic oe_end);
        logic b;
        rx   = 12'h000;
        tail = 11'h000;
        ncs  = 1'b0;
        half_sclk();
        for (int i = 1; i <= n_rises; i++) begin
            case (i)
                6:       mosi = 1'b1;
                7:       mosi = sgl;
                8:       mosi = d[2];
                9:       mosi = d[1];
                10:      mosi = d[0];
                default: mosi = 1'b0;
            endcase
            half_sclk();
            b = miso;
            if (i >= 13 && i <= 24) rx[24-i] = b;
            if (i >= 25 && i <= 35) tail[i-25] = b;
            sclk = 1'b1;
            half_sclk();
            sclk = 1'b0;
        end
        half_sclk();
        oe_end = miso_oe;
        if (!leave_cs) begin
            ncs  = 1'b1;
            mosi = 1'b0;
            half_sclk();
        end
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        sclk     = 1'b0;
        ncs      = 1'b1;
        mosi     = 1'b0;
        scramble = 1'b0;
        ch_fixed = '0;
        ch_rand  = '0;
        repeat (3) @(posedge clock);
        #1;
        n_checks++; if (miso !== 1'b0) begin n_fails++; $display("FAIL reset_miso: got %b want 0", miso); end
        n_checks++; if (miso_oe !== 1'b0) begin n_fails++; $display("FAIL reset_oe: got %b want 0", miso_oe); end
        n_checks++; if (sample_strobe !== 1'b0) begin n_fails++; $display("FAIL reset_strobe: got %b want 0", sample_strobe); end
        n_checks++; if (frame_done !== 1'b0) begin n_fails++; $display("FAIL reset_done: got %b want 0", frame_done); end
        n_checks++; if (frame_error !== 1'b0) begin n_fails++; $display("FAIL reset_error: got %b want 0", frame_error); end
        n_checks++; if (last_cmd !== 4'h0) begin n_fails++; $display("FAIL reset_last_cmd: got %h want 0", last_cmd); end
        reset_n = 1'b1;
        repeat (4) @(posedge clock);
        #1;
    endtask

    task automatic test_single();
        logic [11:0] rx; logic [10:0] tail; logic oe;
        int s0 = n_strobe, d0 = n_done, e0 = n_err;
        set_ch(3, 12'hA5C);
        run_frame(1'b1, 3'd3, 24, 1'b0, rx, tail, oe);
        n_checks++; if (rx !== 12'hA5C) begin n_fails++; $display("FAIL single_rx: got %h want a5c", rx); end
        n_checks++; if (last_cmd !== 4'hB) begin n_fails++; $display("FAIL single_last_cmd: got %h want b", last_cmd); end
        n_checks++; if (n_strobe - s0 !== 1) begin n_fails++; $display("FAIL single_strobes: got %0d want 1", n_strobe - s0); end
        n_checks++; if (n_done - d0 !== 1) begin n_fails++; $display("FAIL single_done: got %0d want 1", n_done - d0); end
        n_checks++; if (n_err - e0 !== 0) begin n_fails++; $display("FAIL single_errors: got %0d want 0", n_err - e0); end
        n_checks++; if (miso_oe !== 1'b0) begin n_fails++; $display("FAIL single_oe_after: got %b want 0", miso_oe); end
    endtask

    task automatic test_differential();
        logic [11:0] rx; logic [10:0] tail; logic oe;
        set_ch(4, 12'h300);
        set_ch(5, 12'h100);
        run_frame(1'b0, 3'd4, 24, 1'b0, rx, tail, oe);
        n_checks++; if (rx !== 12'h200) begin n_fails++; $display("FAIL diff_pos_rx: got %h want 200", rx); end
        n_checks++; if (last_cmd !== 4'h4) begin n_fails++; $display("FAIL diff_last_cmd: got %h want 4", last_cmd); end
        set_ch(4, 12'h100);
        set_ch(5, 12'h300);
        run_frame(1'b0, 3'd4, 24, 1'b0, rx, tail, oe);
        n_checks++; if (rx !== 12'h000) begin n_fails++; $display("FAIL diff_neg_rx: got %h want 000", rx); end
    endtask

    task automatic test_abort();
        logic [11:0] rx; logic [10:0] tail; logic oe;
        int e0 = n_err;
        set_ch(0, 12'h001);
        run_frame(1'b1, 3'd0, 20, 1'b0, rx, tail, oe);
        n_checks++; if (n_err - e0 !== 1) begin n_fails++; $display("FAIL abort_errors: got %0d want 1", n_err - e0); end
        n_checks++; if (miso_oe !== 1'b0) begin n_fails++; $display("FAIL abort_oe: got %b want 0", miso_oe); end
        run_frame(1'b1, 3'd0, 24, 1'b0, rx, tail, oe);
        n_checks++; if (rx !== 12'h001) begin n_fails++; $display("FAIL abort_next_rx: got %h want 001", rx); end
        n_checks++; if (n_err - e0 !== 1) begin n_fails++; $display("FAIL abort_next_errors: got %0d want 1", n_err - e0); end
    endtask

    task automatic test_tail();
        logic [11:0] rx; logic [10:0] tail; logic oe;
        logic [10:0] exp_tail;
`ifdef MCP_LSB_TAIL_EN
        exp_tail = 11'h400;
`else
        exp_tail = 11'h000;
`endif
        set_ch(7, 12'h801);
        run_frame(1'b1, 3'd7, 35, 1'b0, rx, tail, oe);
        n_checks++; if (rx !== 12'h801) begin n_fails++; $display("FAIL tail_rx: got %h want 801", rx); end
        n_checks++; if (tail !== exp_tail) begin n_fails++; $display("FAIL tail_bits: got %b want %b", tail, exp_tail); end
        n_checks++; if (oe !== 1'b1) begin n_fails++; $display("FAIL tail_oe: got %b want 1", oe); end
    endtask

    task automatic test_reset_mid_frame();
        logic [11:0] rx; logic [10:0] tail; logic oe;
        set_ch(5, 12'h3C7);
        run_frame(1'b1, 3'd5, 16, 1'b1, rx, tail, oe);
        n_checks++; if (oe !== 1'b1) begin n_fails++; $display("FAIL midrst_pre_oe: got %b want 1", oe); end
        @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        n_checks++; if (miso !== 1'b0) begin n_fails++; $display("FAIL midrst_miso: got %b want 0", miso); end
        n_checks++; if (miso_oe !== 1'b0) begin n_fails++; $display("FAIL midrst_oe: got %b want 0", miso_oe); end
        n_checks++; if (sample_strobe !== 1'b0) begin n_fails++; $display("FAIL midrst_strobe: got %b want 0", sample_strobe); end
        n_checks++; if (frame_done !== 1'b0) begin n_fails++; $display("FAIL midrst_done: got %b want 0", frame_done); end
        n_checks++; if (frame_error !== 1'b0) begin n_fails++; $display("FAIL midrst_error: got %b want 0", frame_error); end
        n_checks++; if (last_cmd !== 4'h0) begin n_fails++; $display("FAIL midrst_last_cmd: got %h want 0", last_cmd); end
        ncs  = 1'b1;
        mosi = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        reset_n = 1'b1;
        half_sclk();
        run_frame(1'b1, 3'd5, 24, 1'b0, rx, tail, oe);
        n_checks++; if (rx !== 12'h3C7) begin n_fails++; $display("FAIL midrst_next_rx: got %h want 3c7", rx); end
        n_checks++; if (last_cmd !== 4'hD) begin n_fails++; $display("FAIL midrst_next_cmd: got %h want d", last_cmd); end
    endtask

    task automatic test_sample_isolation();
        logic [11:0] rx; logic [10:0] tail; logic oe;
        int s0 = n_strobe;
        ch_rand  = {$urandom(), $urandom(), $urandom()};
        scramble = 1'b1;
        run_frame(1'b1, 3'd2, 24, 1'b0, rx, tail, oe);
        scramble = 1'b0;
        n_checks++; if (n_strobe - s0 !== 1) begin n_fails++; $display("FAIL iso_strobes: got %0d want 1", n_strobe - s0); end
        n_checks++; if (rx !== iso_captured) begin n_fails++; $display("FAIL iso_rx: got %h want %h", rx, iso_captured); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_differential();
        test_abort();
        test_tail();
        test_reset_mid_frame();
        test_sample_isolation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire
